// File: rtl/push_pop_sequencer.sv
// Thumb PUSH/POP sequencer: one register transfer per cycle, then SP write-back.
// Define PUSH_POP_LR_PC_EN to honour the R bit (r14 on PUSH, r15 on POP).
module push_pop_sequencer #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  is_pop_i,
  input  logic [7:0]            reg_list_i,
  input  logic                  lr_pc_bit_i,
  input  logic [WORD-1:0]       stack_pointer_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  stall_fetch_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [WORD-1:0]       mem_addr_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  output logic                  reg_file_write_en_o,
  output logic                  sp_update_en_o,
  output logic [WORD-1:0]       sp_new_o,
  output logic                  pc_flush_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, XFER, SP_WB} state_t;

  state_t                state_q, state_d;
  logic [15:0]           mask_q, mask_d;
  logic [WORD-1:0]       addr_q, addr_d;
  logic [WORD-1:0]       sp_final_q, sp_final_d;
  logic                  upd_q, upd_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  pop_q, pop_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [WORD-1:0]       mem_addr_q, mem_addr_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  rf_q, rf_d;
  logic                  spu_q, spu_d;
  logic [WORD-1:0]       sp_new_q, sp_new_d;
  logic                  done_q, done_d;
  logic                  flush_q, flush_d;

  logic                  r_bit;
  logic [15:0]           start_mask;
  logic [4:0]            n_regs;
  logic [5:0]            off6;
  logic [WORD-1:0]       offw;
  logic [WORD-1:0]       base;
  logic [WORD-1:0]       sp_fin;

  logic                  go;
  logic [15:0]           src_mask;
  logic [WORD-1:0]       src_addr;
  logic                  src_pop;
  logic [3:0]            first;

`ifdef PUSH_POP_LR_PC_EN
  assign r_bit = lr_pc_bit_i;
`else
  logic unused_r_bit;
  assign unused_r_bit = lr_pc_bit_i;
  assign r_bit        = 1'b0;
`endif

  function automatic logic [3:0] lowest(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(m[i]);
    end
    return c;
  endfunction

  assign start_mask = {r_bit & is_pop_i, r_bit & ~is_pop_i,
                       6'b0, reg_list_i};
  assign n_regs = popcnt(start_mask);
  assign off6   = {n_regs[3:0], 2'b00};
  assign offw   = {{(WORD-6){1'b0}}, off6};
  assign base   = is_pop_i ? stack_pointer_i
                           : stack_pointer_i - offw;
  assign sp_fin = is_pop_i ? stack_pointer_i + offw : base;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    sp_final_d   = sp_final_q;
    upd_d        = upd_q;
    flush_pend_d = flush_pend_q;
    pop_d        = pop_q;
    reg_addr_d   = reg_addr_q;
    mem_addr_d   = mem_addr_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    rf_d         = 1'b0;
    spu_d        = 1'b0;
    sp_new_d     = sp_new_q;
    done_d       = 1'b0;
    flush_d      = 1'b0;
    go           = 1'b0;
    src_mask     = mask_q;
    src_addr     = addr_q;
    src_pop      = pop_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pop_d        = is_pop_i;
          sp_final_d   = sp_fin;
          upd_d        = |start_mask;
          flush_pend_d = start_mask[15];
          if (|start_mask) begin
            go       = 1'b1;
            src_mask = start_mask;
            src_addr = base;
            src_pop  = is_pop_i;
            state_d  = XFER;
          end else begin
            state_d  = SP_WB;
            done_d   = 1'b1;
            sp_new_d = '0;
          end
        end
      end
      XFER: begin
        if (!stall_i) begin
          if (|mask_q) begin
            go = 1'b1;
          end else begin
            state_d  = SP_WB;
            done_d   = 1'b1;
            spu_d    = upd_q;
            sp_new_d = upd_q ? sp_final_q : '0;
            flush_d  = flush_pend_q;
          end
        end
      end
      SP_WB: begin
        if (!stall_i) begin
          state_d    = IDLE;
          reg_addr_d = '0;
          mem_addr_d = '0;
          sp_new_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the next transfer is presented one edge early.
    first = lowest(src_mask);
    if (go) begin
      reg_addr_d = ADDR_WIDTH'(first);
      mem_addr_d = src_addr;
      mask_d     = src_mask & ~(16'd1 << first);
      addr_d     = src_addr + WORD'(4);
      we_d       = ~src_pop;
      re_d       = src_pop;
      rf_d       = src_pop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      addr_q       <= '0;
      sp_final_q   <= '0;
      upd_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      pop_q        <= 1'b0;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      rf_q         <= 1'b0;
      spu_q        <= 1'b0;
      sp_new_q     <= '0;
      done_q       <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      sp_final_q   <= sp_final_d;
      upd_q        <= upd_d;
      flush_pend_q <= flush_pend_d;
      pop_q        <= pop_d;
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
      we_q         <= we_d;
      re_q         <= re_d;
      rf_q         <= rf_d;
      spu_q        <= spu_d;
      sp_new_q     <= sp_new_d;
      done_q       <= done_d;
      flush_q      <= flush_d;
    end
  end

  assign busy_o              = (state_q != IDLE);
  assign stall_fetch_o       = (start_i & (state_q == IDLE)) | busy_o;
  assign reg_addr_o          = reg_addr_q;
  assign mem_addr_o          = mem_addr_q;
  assign mem_write_en_o      = we_q;
  assign mem_read_en_o       = re_q;
  assign reg_file_write_en_o = rf_q;
  assign sp_update_en_o      = spu_q;
  assign sp_new_o            = sp_new_q;
  assign pc_flush_o          = flush_q;
  assign done_o              = done_q;

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Directed bench for push_pop_sequencer; expectations follow
// PUSH_POP_LR_PC_EN when it is defined for the build.
module tb_push_pop_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        is_pop_i;
  logic [7:0]  reg_list_i;
  logic        lr_pc_bit_i;
  logic [31:0] stack_pointer_i;
  logic        stall_i;
  logic        busy_o;
  logic        stall_fetch_o;
  logic [3:0]  reg_addr_o;
  logic [31:0] mem_addr_o;
  logic        mem_write_en_o;
  logic        mem_read_en_o;
  logic        reg_file_write_en_o;
  logic        sp_update_en_o;
  logic [31:0] sp_new_o;
  logic        pc_flush_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  // flag order: busy, we, re, rf, spu, done, flush
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_STL  = 7'b1000000;
  localparam logic [6:0] F_WR   = 7'b1100000;
  localparam logic [6:0] F_RD   = 7'b1011000;
  localparam logic [6:0] F_WB   = 7'b1000110;
  localparam logic [6:0] F_WB0  = 7'b1000010;
  localparam logic [6:0] F_WBF  = 7'b1000111;

  push_pop_sequencer dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .is_pop_i            (is_pop_i),
    .reg_list_i          (reg_list_i),
    .lr_pc_bit_i         (lr_pc_bit_i),
    .stack_pointer_i     (stack_pointer_i),
    .stall_i             (stall_i),
    .busy_o              (busy_o),
    .stall_fetch_o       (stall_fetch_o),
    .reg_addr_o          (reg_addr_o),
    .mem_addr_o          (mem_addr_o),
    .mem_write_en_o      (mem_write_en_o),
    .mem_read_en_o       (mem_read_en_o),
    .reg_file_write_en_o (reg_file_write_en_o),
    .sp_update_en_o      (sp_update_en_o),
    .sp_new_o            (sp_new_o),
    .pc_flush_o          (pc_flush_o),
    .done_o              (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic see(input string tag, input logic [6:0] f,
                     input logic [3:0] ra, input logic [31:0] ma,
                     input logic [31:0] spn);
    logic [6:0] obs;
    obs = {busy_o, mem_write_en_o, mem_read_en_o,
           reg_file_write_en_o, sp_update_en_o, done_o, pc_flush_o};
    chk({tag, ".flags"}, 32'(obs), 32'(f));
    if (f[5] | f[4]) begin
      chk({tag, ".reg"}, 32'(reg_addr_o), 32'(ra));
      chk({tag, ".addr"}, mem_addr_o, ma);
    end
    if (f[1]) chk({tag, ".sp"}, sp_new_o, spn);
  endtask

  task automatic start(input string tag, input logic pop,
                       input logic [7:0] list, input logic r,
                       input logic [31:0] sp);
    start_i         = 1'b1;
    is_pop_i        = pop;
    reg_list_i      = list;
    lr_pc_bit_i     = r;
    stack_pointer_i = sp;
    #1;
    chk({tag, ".sfetch"}, 32'(stall_fetch_o), 32'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    reset_i         = 1'b1;
    start_i         = 1'b0;
    is_pop_i        = 1'b0;
    reg_list_i      = 8'h00;
    lr_pc_bit_i     = 1'b0;
    stack_pointer_i = 32'h0;
    stall_i         = 1'b0;
    repeat (2) tick();

    chk("rst.flags", 32'({busy_o, mem_write_en_o, mem_read_en_o,
        reg_file_write_en_o, sp_update_en_o, done_o, pc_flush_o}), 32'd0);
    chk("rst.reg", 32'(reg_addr_o), 32'd0);
    chk("rst.addr", mem_addr_o, 32'd0);
    chk("rst.sp", sp_new_o, 32'd0);
    chk("rst.sfetch", 32'(stall_fetch_o), 32'd0);
    reset_i = 1'b0;
    tick();
    see("idle", F_IDLE, 4'd0, 32'h0, 32'h0);

    // PUSH {r0,r2,r4,lr}, SP=0x1000
    start("push4", 1'b0, 8'h15, 1'b1, 32'h0000_1000);
`ifdef PUSH_POP_LR_PC_EN
    see("push4.x0", F_WR, 4'd0, 32'h0000_0FF0, 0); tick();
    chk("push4.sfetch_busy", 32'(stall_fetch_o), 32'd1);
    see("push4.x1", F_WR, 4'd2, 32'h0000_0FF4, 0); tick();
    see("push4.x2", F_WR, 4'd4, 32'h0000_0FF8, 0); tick();
    see("push4.x3", F_WR, 4'd14, 32'h0000_0FFC, 0); tick();
    see("push4.wb", F_WB, 4'd0, 0, 32'h0000_0FF0); tick();
`else
    see("push4.x0", F_WR, 4'd0, 32'h0000_0FF4, 0); tick();
    chk("push4.sfetch_busy", 32'(stall_fetch_o), 32'd1);
    see("push4.x1", F_WR, 4'd2, 32'h0000_0FF8, 0); tick();
    see("push4.x2", F_WR, 4'd4, 32'h0000_0FFC, 0); tick();
    see("push4.wb", F_WB, 4'd0, 0, 32'h0000_0FF4); tick();
`endif
    see("push4.end", F_IDLE, 4'd0, 0, 0);

    // POP {r1,pc}, SP=0x0FF0
    start("pop2", 1'b1, 8'h02, 1'b1, 32'h0000_0FF0);
    see("pop2.x0", F_RD, 4'd1, 32'h0000_0FF0, 0); tick();
`ifdef PUSH_POP_LR_PC_EN
    see("pop2.x1", F_RD, 4'd15, 32'h0000_0FF4, 0); tick();
    see("pop2.wb", F_WBF, 4'd0, 0, 32'h0000_0FF8); tick();
`else
    see("pop2.wb", F_WB, 4'd0, 0, 32'h0000_0FF4); tick();
`endif
    see("pop2.end", F_IDLE, 4'd0, 0, 0);

    // empty list: straight to SP_WB, no SP update
    start("empty", 1'b0, 8'h00, 1'b0, 32'h0000_0800);
    see("empty.wb", F_WB0, 4'd0, 0, 32'h0);
    tick();
    see("empty.end", F_IDLE, 4'd0, 0, 0);

    // PUSH {r3,r7}, SP=4, two stalled cycles, address wrap
    start("p37", 1'b0, 8'h88, 1'b0, 32'h0000_0004);
    see("p37.x0", F_WR, 4'd3, 32'hFFFF_FFFC, 0);
    stall_i = 1'b1;
    tick();
    see("p37.s0", F_STL, 4'd0, 0, 0);
    chk("p37.s0.hold", mem_addr_o, 32'hFFFF_FFFC);
    tick();
    see("p37.s1", F_STL, 4'd0, 0, 0);
    stall_i = 1'b0;
    tick();
    see("p37.x1", F_WR, 4'd7, 32'h0000_0000, 0); tick();
    see("p37.wb", F_WB, 4'd0, 0, 32'hFFFF_FFFC); tick();
    see("p37.end", F_IDLE, 4'd0, 0, 0);

    // reset in the second transfer of a 4-register PUSH
    start("rstm", 1'b0, 8'h0F, 1'b0, 32'h0000_2000);
    see("rstm.x0", F_WR, 4'd0, 32'h0000_1FF0, 0); tick();
    see("rstm.x1", F_WR, 4'd1, 32'h0000_1FF4, 0);
    reset_i = 1'b1;
    tick();
    see("rstm.r", F_IDLE, 4'd0, 0, 0);
    chk("rstm.reg", 32'(reg_addr_o), 32'd0);
    chk("rstm.addr", mem_addr_o, 32'd0);
    chk("rstm.sp", sp_new_o, 32'd0);
    reset_i = 1'b0;
    tick();
    see("rstm.i0", F_IDLE, 4'd0, 0, 0); tick();
    see("rstm.i1", F_IDLE, 4'd0, 0, 0);

    // start_i held while busy is ignored
    start("busy", 1'b0, 8'h20, 1'b0, 32'h0000_0100);
    start_i = 1'b1;
    reg_list_i = 8'hFF;
    stack_pointer_i = 32'h0;
    see("busy.x0", F_WR, 4'd5, 32'h0000_00FC, 0); tick();
    see("busy.wb", F_WB, 4'd0, 0, 32'h0000_00FC);
    start_i = 1'b0;
    tick();
    see("busy.end", F_IDLE, 4'd0, 0, 0);

    // PUSH {r0} with R=1, stall_i high at the accepting edge
    stall_i = 1'b1;
    start("r0r", 1'b0, 8'h01, 1'b1, 32'h0000_0040);
    stall_i = 1'b0;
`ifdef PUSH_POP_LR_PC_EN
    see("r0r.x0", F_WR, 4'd0, 32'h0000_0038, 0); tick();
    see("r0r.x1", F_WR, 4'd14, 32'h0000_003C, 0); tick();
    see("r0r.wb", F_WB, 4'd0, 0, 32'h0000_0038); tick();
`else
    see("r0r.x0", F_WR, 4'd0, 32'h0000_003C, 0); tick();
    see("r0r.wb", F_WB, 4'd0, 0, 32'h0000_003C); tick();
`endif
    see("r0r.end", F_IDLE, 4'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
